// File: rtl/trig_burst_sequencer.sv
// Triggered burst sequencer.
// On an accepted start it runs an optional pre-burst delay, a gated fastclk/2
// burst of a configured number of periods and an optional trigger pulse, then
// reports completion with a one-cycle done pulse and a completed-run counter.
// Every output is a register loaded from the next state and next counter value,
// so outputs change exactly on the edge where the state changes.
module trig_burst_sequencer #(
  parameter int CNT_W = 8,
  parameter int TOT_W = 16
) (
  input  logic             fastclk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_cycles,
  input  logic [CNT_W-1:0] cfg_trig_len,
  output logic             clk_out,
  output logic             trig_out,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [TOT_W-1:0] burst_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DELAY = 3'd1,
    BURST = 3'd2,
    TRIG  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // The phase counter is one bit wider than the fields so that 2*C - 1 for
  // the largest C still fits.
  localparam logic [CNT_W:0]   CNT_ONE   = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] FIELD_ZERO = '0;
  localparam logic [TOT_W-1:0] TOT_ONE   = {{(TOT_W-1){1'b0}}, 1'b1};

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W:0]   cnt_reg;
  logic [CNT_W:0]   cnt_next;
  logic [CNT_W-1:0] delay_reg;
  logic [CNT_W-1:0] cycles_reg;
  logic [CNT_W-1:0] trig_len_reg;
  logic             load_cfg;
  logic             abort_hit;
  logic             count_hit;

  // First phase whose length field is nonzero; DONE when every field is zero.
  function automatic state_t first_phase(input logic [CNT_W-1:0] d,
                                         input logic [CNT_W-1:0] c,
                                         input logic [CNT_W-1:0] t);
    state_t s;
    if (d != FIELD_ZERO)      s = DELAY;
    else if (c != FIELD_ZERO) s = BURST;
    else if (t != FIELD_ZERO) s = TRIG;
    else                      s = DONE;
    return s;
  endfunction

  // Counter value on the first cycle of a phase: remaining cycles minus one,
  // so the phase ends on the cycle where the counter reads zero. In BURST the
  // counter starts odd, which makes bit 0 the slow-clock high phase.
  function automatic logic [CNT_W:0] phase_len_m1(input state_t s,
                                                  input logic [CNT_W-1:0] d,
                                                  input logic [CNT_W-1:0] c,
                                                  input logic [CNT_W-1:0] t);
    logic [CNT_W:0] v;
    case (s)
      DELAY:   v = {1'b0, d} - CNT_ONE;
      BURST:   v = {c, 1'b0} - CNT_ONE;
      TRIG:    v = {1'b0, t} - CNT_ONE;
      default: v = '0;
    endcase
    return v;
  endfunction

  // Next-state and next-counter selection, with abort overriding every
  // non-idle transition.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load_cfg   = 1'b0;
    abort_hit  = 1'b0;
    count_hit  = 1'b0;
    case (state_reg)
      IDLE: begin
        // abort in IDLE wins over start and produces no aborted pulse
        if (start && !abort) begin
          load_cfg   = 1'b1;
          state_next = first_phase(cfg_delay, cfg_cycles, cfg_trig_len);
          cnt_next   = phase_len_m1(state_next, cfg_delay, cfg_cycles, cfg_trig_len);
        end
      end
      DELAY: begin
        if (cnt_reg == '0) begin
          state_next = first_phase(FIELD_ZERO, cycles_reg, trig_len_reg);
          cnt_next   = phase_len_m1(state_next, delay_reg, cycles_reg, trig_len_reg);
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      BURST: begin
        if (cnt_reg == '0) begin
          state_next = first_phase(FIELD_ZERO, FIELD_ZERO, trig_len_reg);
          cnt_next   = phase_len_m1(state_next, delay_reg, cycles_reg, trig_len_reg);
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      TRIG: begin
        if (cnt_reg == '0) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      DONE: begin
        // the run is only counted once DONE is left without an abort
        state_next = IDLE;
        cnt_next   = '0;
        count_hit  = 1'b1;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    if (state_reg != IDLE && abort) begin
      state_next = IDLE;
      cnt_next   = '0;
      abort_hit  = 1'b1;
      count_hit  = 1'b0;
    end
  end

  // State, counters, latched configuration and registered outputs.
  always_ff @(posedge fastclk) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      delay_reg    <= '0;
      cycles_reg   <= '0;
      trig_len_reg <= '0;
      clk_out      <= 1'b0;
      trig_out     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      burst_cnt    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (load_cfg) begin
        delay_reg    <= cfg_delay;
        cycles_reg   <= cfg_cycles;
        trig_len_reg <= cfg_trig_len;
      end
      clk_out  <= (state_next == BURST) && cnt_next[0];
      trig_out <= (state_next == TRIG);
      busy     <= (state_next != IDLE);
      done     <= (state_next == DONE);
      aborted  <= abort_hit;
      if (count_hit) begin
        burst_cnt <= burst_cnt + TOT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_trig_burst_sequencer.sv
// Directed bench for trig_burst_sequencer (CNT_W=8, TOT_W=2 so the completed
// run counter wraps quickly). Inputs change and outputs are sampled 1 time
// unit after each rising edge; "busy cycle n" is the n-th cycle after the
// edge that accepted start.
module tb_trig_burst_sequencer;

  localparam int CNT_W = 8;
  localparam int TOT_W = 2;

  logic             fastclk;
  logic             reset;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] cfg_delay;
  logic [CNT_W-1:0] cfg_cycles;
  logic [CNT_W-1:0] cfg_trig_len;
  logic             clk_out;
  logic             trig_out;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [TOT_W-1:0] burst_cnt;

  int checks;
  int failures;
  logic [TOT_W-1:0] exp_cnt;

  // trace of one run, bit i = busy cycle i+1
  int          blen;
  int          clk_ones;
  logic [15:0] clk_vec;
  logic [15:0] trig_vec;
  logic [15:0] done_vec;
  logic        abort_seen;

  trig_burst_sequencer #(.CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
    .fastclk      (fastclk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .cfg_delay    (cfg_delay),
    .cfg_cycles   (cfg_cycles),
    .cfg_trig_len (cfg_trig_len),
    .clk_out      (clk_out),
    .trig_out     (trig_out),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .burst_cnt    (burst_cnt)
  );

  initial fastclk = 1'b0;
  always #5 fastclk = ~fastclk;

  task automatic step();
    @(posedge fastclk);
    #1;
  endtask

  // Present start for one edge; returns in busy cycle 1.
  task automatic pulse_start(input logic [CNT_W-1:0] d, input logic [CNT_W-1:0] c,
                             input logic [CNT_W-1:0] t);
    cfg_delay    = d;
    cfg_cycles   = c;
    cfg_trig_len = t;
    start        = 1'b1;
    step();
    start        = 1'b0;
  endtask

  // Record outputs while busy, bounded; returns in the first idle cycle.
  task automatic capture(input int max);
    blen       = 0;
    clk_ones   = 0;
    clk_vec    = '0;
    trig_vec   = '0;
    done_vec   = '0;
    abort_seen = 1'b0;
    while (busy === 1'b1 && blen < max) begin
      if (blen < 16) begin
        clk_vec[blen]  = clk_out;
        trig_vec[blen] = trig_out;
        done_vec[blen] = done;
      end
      if (clk_out === 1'b1) clk_ones++;
      if (aborted === 1'b1) abort_seen = 1'b1;
      blen++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({clk_out, trig_out, busy, done, aborted, burst_cnt} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs: got clk=%b trig=%b busy=%b done=%b aborted=%b cnt=%0d, want all 0",
               clk_out, trig_out, busy, done, aborted, burst_cnt);
    end
    // start in the very first cycle with reset low is accepted
    reset = 1'b0;
    pulse_start(8'd0, 8'd0, 8'd1);
    checks++;
    if (busy !== 1'b1 || trig_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_start: got busy=%b trig=%b, want busy=1 trig=1", busy, trig_out);
    end
    capture(20);
    exp_cnt = exp_cnt + 2'd1;
    checks++;
    if (blen != 2 || burst_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL reset_first_run: got len=%0d cnt=%0d, want len=2 cnt=%0d", blen, burst_cnt, exp_cnt);
    end
  endtask

  task automatic test_normal();
    pulse_start(8'd3, 8'd2, 8'd1);
    capture(50);
    exp_cnt = exp_cnt + 2'd1;
    checks++;
    if (blen != 9) begin
      failures++;
      $display("FAIL normal_len: got %0d busy cycles, want 9", blen);
    end
    checks++;
    if (clk_vec !== 16'h0028) begin
      failures++;
      $display("FAIL normal_clk: got %h, want 0028", clk_vec);
    end
    checks++;
    if (trig_vec !== 16'h0080) begin
      failures++;
      $display("FAIL normal_trig: got %h, want 0080", trig_vec);
    end
    checks++;
    if (done_vec !== 16'h0100) begin
      failures++;
      $display("FAIL normal_done: got %h, want 0100", done_vec);
    end
    checks++;
    if (burst_cnt !== exp_cnt || done !== 1'b0) begin
      failures++;
      $display("FAIL normal_cnt: got cnt=%0d done=%b, want cnt=%0d done=0", burst_cnt, done, exp_cnt);
    end
  endtask

  task automatic test_zero_fields();
    pulse_start(8'd0, 8'd0, 8'd0);
    capture(20);
    exp_cnt = exp_cnt + 2'd1;
    checks++;
    if (blen != 1 || done_vec !== 16'h0001 || burst_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL zero_all: got len=%0d done=%h cnt=%0d, want len=1 done=0001 cnt=%0d",
               blen, done_vec, burst_cnt, exp_cnt);
    end
    pulse_start(8'd0, 8'd1, 8'd0);
    capture(20);
    exp_cnt = exp_cnt + 2'd1;
    checks++;
    if (blen != 3 || clk_vec !== 16'h0001 || trig_vec !== 16'h0000 || done_vec !== 16'h0004) begin
      failures++;
      $display("FAIL zero_c1: got len=%0d clk=%h trig=%h done=%h, want len=3 clk=0001 trig=0000 done=0004",
               blen, clk_vec, trig_vec, done_vec);
    end
  endtask

  task automatic test_abort_burst();
    pulse_start(8'd0, 8'd4, 8'd0);
    step();
    step();
    abort = 1'b1;   // present during busy cycle 3
    step();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || aborted !== 1'b1 || clk_out !== 1'b0 || done !== 1'b0 || burst_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL abort_burst: got busy=%b aborted=%b clk=%b done=%b cnt=%0d, want 0 1 0 0 %0d",
               busy, aborted, clk_out, done, burst_cnt, exp_cnt);
    end
    step();
    checks++;
    if (aborted !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_pulse_width: got aborted=%b done=%b, want 0 0", aborted, done);
    end
  endtask

  task automatic test_back_to_back();
    pulse_start(8'd2, 8'd1, 8'd2);
    // restart and new config while in DELAY: both must be ignored
    cfg_delay    = 8'd7;
    cfg_cycles   = 8'd7;
    cfg_trig_len = 8'd7;
    start        = 1'b1;
    step();
    start        = 1'b0;
    capture(50);
    exp_cnt = exp_cnt + 2'd1;
    checks++;
    if (blen != 6 || clk_vec !== 16'h0002 || trig_vec !== 16'h0018 || done_vec !== 16'h0020) begin
      failures++;
      $display("FAIL busy_restart: got len=%0d clk=%h trig=%h done=%h, want len=6 clk=0002 trig=0018 done=0020",
               blen, clk_vec, trig_vec, done_vec);
    end
    checks++;
    if (burst_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL busy_restart_cnt: got %0d, want %0d", burst_cnt, exp_cnt);
    end
    // start presented during the DONE cycle is dropped
    pulse_start(8'd0, 8'd0, 8'd1);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    exp_cnt = exp_cnt + 2'd1;
    checks++;
    if (busy !== 1'b0 || burst_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL start_in_done: got busy=%b cnt=%0d, want busy=0 cnt=%0d", busy, burst_cnt, exp_cnt);
    end
    step();
  endtask

  task automatic test_abort_done_idle();
    pulse_start(8'd0, 8'd0, 8'd1);
    step();
    abort = 1'b1;   // present during the DONE cycle
    step();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || aborted !== 1'b1 || done !== 1'b0 || burst_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL abort_done: got busy=%b aborted=%b done=%b cnt=%0d, want 0 1 0 %0d",
               busy, aborted, done, burst_cnt, exp_cnt);
    end
    // abort in IDLE beats start and raises nothing
    abort = 1'b1;
    pulse_start(8'd0, 8'd1, 8'd0);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || aborted !== 1'b0 || clk_out !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: got busy=%b aborted=%b clk=%b, want 0 0 0", busy, aborted, clk_out);
    end
  endtask

  task automatic test_reset_trig();
    pulse_start(8'd1, 8'd1, 8'd3);
    step();
    step();
    step();
    checks++;
    if (trig_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_trig_setup: got trig=%b, want 1", trig_out);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_cnt = '0;
    checks++;
    if ({clk_out, trig_out, busy, done, aborted, burst_cnt} !== 7'b0) begin
      failures++;
      $display("FAIL reset_trig: got clk=%b trig=%b busy=%b done=%b aborted=%b cnt=%0d, want all 0",
               clk_out, trig_out, busy, done, aborted, burst_cnt);
    end
    pulse_start(8'd1, 8'd0, 8'd1);
    capture(20);
    exp_cnt = exp_cnt + 2'd1;
    checks++;
    if (blen != 3 || trig_vec !== 16'h0002 || done_vec !== 16'h0004 || burst_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL reset_trig_rerun: got len=%0d trig=%h done=%h cnt=%0d, want 3 0002 0004 %0d",
               blen, trig_vec, done_vec, burst_cnt, exp_cnt);
    end
  endtask

  task automatic test_max_cycles();
    pulse_start(8'd0, 8'd255, 8'd0);
    capture(600);
    exp_cnt = exp_cnt + 2'd1;
    checks++;
    if (blen != 511 || clk_ones != 255 || burst_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL max_cycles: got len=%0d clk_highs=%0d cnt=%0d, want 511 255 %0d",
               blen, clk_ones, burst_cnt, exp_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [TOT_W-1:0] seq [0:3];
    seq[0] = 2'd1;
    seq[1] = 2'd2;
    seq[2] = 2'd3;
    seq[3] = 2'd0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pulse_start(8'd0, 8'd0, 8'd0);
      capture(20);
      checks++;
      if (burst_cnt !== seq[i]) begin
        failures++;
        $display("FAIL wrap_run%0d: got cnt=%0d, want %0d", i, burst_cnt, seq[i]);
      end
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    exp_cnt      = '0;
    reset        = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    cfg_delay    = '0;
    cfg_cycles   = '0;
    cfg_trig_len = '0;
    test_reset();
    test_normal();
    test_zero_fields();
    test_abort_burst();
    test_back_to_back();
    test_abort_done_idle();
    test_reset_trig();
    test_max_cycles();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trig_burst_sequencer.md
TRIG_BURST_SEQUENCER -- requirements
Module: trig_burst_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the delay, cycle and trigger-length configuration fields.
REQ-002 SHALL have parameter TOT_W, default 16: width of the completed-burst counter.
REQ-003 SHALL have port fastclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: request to run one burst; sampled in IDLE only.
REQ-006 SHALL have port abort, input, 1 bit: cancels a running burst.
REQ-007 SHALL have port cfg_delay, input, CNT_W bits: pre-burst delay in fastclk cycles.
REQ-008 SHALL have port cfg_cycles, input, CNT_W bits: number of slow-clock periods in the burst.
REQ-009 SHALL have port cfg_trig_len, input, CNT_W bits: trigger pulse width in fastclk cycles.
REQ-010 SHALL have port clk_out, output, 1 bit: gated slow clock, fastclk/2, high on the first cycle of each period.
REQ-011 SHALL have port trig_out, output, 1 bit: trigger pulse following the burst.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse on normal completion.
REQ-014 SHALL have port aborted, output, 1 bit: one-cycle pulse when abort cancels a run.
REQ-015 SHALL have port burst_cnt, output, TOT_W bits: count of normally completed bursts.

Function
REQ-016 SHALL implement states IDLE, DELAY, BURST, TRIG and DONE; all outputs are registered and decoded from the current state and counters.
REQ-017 In IDLE with start=1 and abort=0, the block SHALL latch cfg_delay, cfg_cycles and cfg_trig_len into shadow registers and leave IDLE at the next edge.
- Target state is the first of DELAY/BURST/TRIG whose latched field is nonzero.
- If all three fields are zero, the target is DONE.
REQ-018 Config inputs SHALL be ignored outside the start-acceptance cycle, so mid-run changes have no effect.
REQ-019 DELAY SHALL last exactly D latched-delay cycles; clk_out=0 and trig_out=0 throughout.
REQ-020 BURST SHALL last exactly 2*C cycles.
- clk_out=1 on the 1st, 3rd, 5th, ... cycles and 0 on the others.
- trig_out=0 throughout.
REQ-021 TRIG SHALL last exactly T cycles with trig_out=1 and clk_out=0.
REQ-022 Each of DELAY, BURST and TRIG SHALL be skipped when its latched field is zero; the next nonzero phase, or DONE, follows directly.
REQ-023 DONE SHALL last 1 cycle with done=1, then return to IDLE; burst_cnt increments by 1 in that cycle and wraps from all-ones to 0.
REQ-024 Total busy time SHALL be D+2C+T+1 cycles, with the first busy cycle one edge after start is sampled.
REQ-025 start while busy=1 SHALL be ignored and not queued.
REQ-026 A start sampled in the DONE cycle SHALL be ignored; a new start is accepted only in IDLE, giving a minimum one-cycle IDLE gap.
REQ-027 abort=1 in DELAY, BURST, TRIG or DONE SHALL force IDLE at the next edge.
- In that next cycle: aborted=1, clk_out=0, trig_out=0, busy=0.
- done is not asserted and burst_cnt is not incremented.
REQ-028 abort in the DONE cycle SHALL abort: no done pulse, no count.
REQ-029 abort=1 in IDLE SHALL have priority over start: start is ignored, no state change, aborted stays 0.
REQ-030 Counter arithmetic SHALL use CNT_W+1 bits so that 2*C for C = 2^CNT_W - 1 does not overflow.

Reset
REQ-031 reset=1 at a rising edge SHALL force IDLE, in any state and also mid-burst.
- Output values: clk_out=0, trig_out=0, busy=0, done=0, aborted=0, burst_cnt=0.
- Shadow registers and counters are cleared to 0.
REQ-032 reset SHALL have priority over start and abort.
REQ-033 The first start SHALL be accepted in the first cycle with reset=0.

Verification
REQ-034 Normal run: D=3, C=2, T=1, start pulsed -> busy for 9 cycles, delay phase, clk_out pattern 1,0,1,0 on busy cycles 4-7, trig_out=1 on cycle 8, done=1 on cycle 9, burst_cnt=1.
REQ-035 Zero fields: D=0, C=0, T=0 -> busy for 1 cycle with done=1; D=0, C=1, T=0 -> clk_out 1,0 then done, 3 busy cycles.
REQ-036 Abort mid-BURST: D=0, C=4, abort on busy cycle 3 -> busy=0 with aborted=1 next cycle, clk_out=0, no done pulse, burst_cnt unchanged.
REQ-037 Start while busy, and config change mid-run: start re-pulsed in DELAY and cfg changed -> ignored; timing follows the latched values.
REQ-038 Synchronous reset during TRIG -> all outputs 0 at the next edge; start on the following cycle is accepted and the run completes normally.
REQ-039 Wrap: TOT_W=2, 4 completed runs -> burst_cnt sequence 1, 2, 3, 0.
